// File: rtl/hs32_alu_wb.sv
// hs32_alu_wb: HS32 ALU writeback stage.
// Holds the architectural NZCV register, buffers register writes in order
// ahead of the register-file port, and reports read-after-write hazards.
// Optional feature macro: HS32_WB_FWD_EN (forward the youngest matching
// buffered value instead of stalling decode).
module hs32_alu_wb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_res,
  input  logic [3:0]  i_fl,
  input  logic [3:0]  i_rd,
  input  logic        i_wr_rd,
  input  logic        i_wr_fl,
  output logic [3:0]  o_fl,
  output logic        o_we,
  output logic [3:0]  o_waddr,
  output logic [31:0] o_wdata,
  input  logic        i_rf_ready,
  input  logic [3:0]  i_hz_rd,
  output logic        o_hazard,
  output logic        o_fwd_hit,
  output logic [31:0] o_fwd_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [DEPTH-1:0] buf_q, buf_d;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [3:0]          fl_q, fl_d;
  logic                accept, enq, deq;

  assign o_ready = (count_q < CW'(DEPTH));
  assign o_we    = (count_q != '0);
  assign o_waddr = buf_q[head_q].rd;
  assign o_wdata = buf_q[head_q].data;
  assign o_fl    = fl_q;

  // Next-state: enqueue at tail, dequeue at head, flags taken at accept time.
  always_comb begin
    accept  = i_valid && o_ready;
    enq     = accept && i_wr_rd;
    deq     = o_we && i_rf_ready;
    buf_d   = buf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fl_d    = fl_q;
    if (enq) begin
      buf_d[tail_q] = '{rd: i_rd, data: i_res};
      tail_d        = tail_q + 1'b1;
    end
    if (deq) head_d = head_q + 1'b1;
    if (accept && i_wr_fl) fl_d = i_fl;
    count_d = count_q + CW'(enq) - CW'(deq);
  end

  // State registers; reset discards any pending writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      fl_q    <= '0;
    end else begin
      buf_q   <= buf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      fl_q    <= fl_d;
    end
  end

`ifdef HS32_WB_FWD_EN
  logic        match;
  logic [31:0] fwd_data;
  logic [PW-1:0] idx;

  // Scan valid entries oldest to youngest; the last hit is the youngest.
  always_comb begin
    match    = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (buf_q[idx].rd == i_hz_rd)) begin
        match    = 1'b1;
        fwd_data = buf_q[idx].data;
      end
    end
  end

  assign o_fwd_hit  = match;
  assign o_fwd_data = fwd_data;
  assign o_hazard   = 1'b0;
`else
  logic          match;
  logic [PW-1:0] idx;

  // Any valid entry targeting the read register stalls decode.
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (buf_q[idx].rd == i_hz_rd)) match = 1'b1;
    end
  end

  assign o_fwd_hit  = 1'b0;
  assign o_fwd_data = '0;
  assign o_hazard   = match;
`endif

endmodule

// File: tb/tb_hs32_alu_wb.sv
// Self-checking bench for hs32_alu_wb: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_hs32_alu_wb;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_wr_rd, i_wr_fl, i_rf_ready;
  logic [31:0] i_res;
  logic [3:0]  i_fl, i_rd, i_hz_rd;
  logic        o_ready, o_we, o_hazard, o_fwd_hit;
  logic [3:0]  o_fl, o_waddr;
  logic [31:0] o_wdata, o_fwd_data;

  hs32_alu_wb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_res(i_res), .i_fl(i_fl), .i_rd(i_rd), .i_wr_rd(i_wr_rd),
    .i_wr_fl(i_wr_fl), .o_fl(o_fl), .o_we(o_we), .o_waddr(o_waddr),
    .o_wdata(o_wdata), .i_rf_ready(i_rf_ready), .i_hz_rd(i_hz_rd),
    .o_hazard(o_hazard), .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  mfl;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the currently driven inputs.
  task automatic check_model();
    bit          hit;
    logic [31:0] hdata;
    hit = 1'b0;
    hdata = '0;
    for (int k = mq.size() - 1; k >= 0; k--)
      if (!hit && mq[k].rd == i_hz_rd) begin
        hit = 1'b1;
        hdata = mq[k].data;
      end
    chk("ready", o_ready, 32'(mq.size() < DEPTH));
    chk("we", o_we, 32'(mq.size() != 0));
    chk("fl", o_fl, 32'(mfl));
    if (mq.size() != 0) begin
      chk("waddr", o_waddr, 32'(mq[0].rd));
      chk("wdata", o_wdata, mq[0].data);
    end
`ifdef HS32_WB_FWD_EN
    chk("fwd_hit", o_fwd_hit, 32'(hit));
    if (hit) chk("fwd_data", o_fwd_data, hdata);
    chk("hazard", o_hazard, 32'd0);
`else
    chk("hazard", o_hazard, 32'(hit));
    chk("fwd_hit", o_fwd_hit, 32'd0);
    chk("fwd_data", o_fwd_data, 32'd0);
`endif
  endtask

  // One cycle, entered just after a falling edge: drive, check, clock, update model.
  task automatic step(input bit v, input logic [31:0] res, input logic [3:0] fl,
                      input logic [3:0] rd, input bit wrd, input bit wfl,
                      input bit rfr, input logic [3:0] hz);
    bit acc, dq;
    i_valid = v; i_res = res; i_fl = fl; i_rd = rd;
    i_wr_rd = wrd; i_wr_fl = wfl; i_rf_ready = rfr; i_hz_rd = hz;
    #1;
    check_model();
    acc = v && (mq.size() < DEPTH);
    dq  = (mq.size() != 0) && rfr;
    @(posedge clk);
    if (dq) void'(mq.pop_front());
    if (acc && wrd) mq.push_back('{rd: rd, data: res});
    if (acc && wfl) mfl = fl;
    @(negedge clk);
  endtask

  initial begin
    mfl = 4'b0000;
    reset = 1'b1;
    i_valid = 1'b1; i_res = 32'hDEADBEEF; i_fl = 4'hF; i_rd = 4'd9;
    i_wr_rd = 1'b1; i_wr_fl = 1'b1; i_rf_ready = 1'b0; i_hz_rd = 4'd9;
    repeat (2) @(negedge clk);
    chk("rst_fl", o_fl, 32'd0);
    chk("rst_we", o_we, 32'd0);
    chk("rst_ready", o_ready, 32'd1);
    chk("rst_waddr", o_waddr, 32'd0);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_hazard", o_hazard, 32'd0);
    chk("rst_fwd_hit", o_fwd_hit, 32'd0);
    reset = 1'b0;

    // First op and its one-cycle latency.
    step(1, 32'h12345678, 4'b0100, 4'd3, 1, 1, 0, 4'd0);
    chk("first_we", o_we, 32'd1);
    chk("first_waddr", o_waddr, 32'd3);
    chk("first_wdata", o_wdata, 32'h12345678);
    chk("first_fl", o_fl, 32'b0100);
    step(0, 0, 0, 0, 0, 0, 1, 4'd0);

    // Fill and back-pressure.
    step(1, 32'h111, 4'h1, 4'd1, 1, 0, 0, 4'd0);
    step(1, 32'h222, 4'h2, 4'd2, 1, 0, 0, 4'd0);
    chk("full_ready", o_ready, 32'd0);
    step(1, 32'h777, 4'h7, 4'd7, 1, 1, 0, 4'd0);
    chk("full_waddr", o_waddr, 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 4'd0);
    chk("drain2_waddr", o_waddr, 32'd2);
    step(0, 0, 0, 0, 0, 0, 1, 4'd0);
    chk("drained_we", o_we, 32'd0);

    // Flag-only op.
    step(1, 32'h999, 4'b0010, 4'd9, 0, 1, 1, 4'd9);
    chk("flonly_fl", o_fl, 32'b0010);
    chk("flonly_we", o_we, 32'd0);

    // Simultaneous enqueue/dequeue across pointer wrap.
    step(1, 32'h4040, 4'h0, 4'd4, 1, 0, 0, 4'd0);
    for (int i = 0; i < 10; i++)
      step(1, 32'(i) * 32'h11, 4'(i), 4'(i), 1, 1, 1, 4'(i));
    chk("simul_ready", o_ready, 32'd1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 1, 4'd0);

    // Hazard / forwarding with two entries for rd=5.
    step(1, 32'hAAAA, 4'h0, 4'd5, 1, 0, 0, 4'd5);
    step(1, 32'hBBBB, 4'h0, 4'd5, 1, 0, 0, 4'd5);
    i_valid = 1'b0; i_hz_rd = 4'd5; #1;
`ifdef HS32_WB_FWD_EN
    chk("hz5_hit", o_fwd_hit, 32'd1);
    chk("hz5_data", o_fwd_data, 32'hBBBB);
    chk("hz5_hazard", o_hazard, 32'd0);
`else
    chk("hz5_hazard", o_hazard, 32'd1);
`endif
    i_hz_rd = 4'd6; #1;
    chk("hz6_hit", o_fwd_hit, 32'd0);
    chk("hz6_hazard", o_hazard, 32'd0);

    // Reset mid-drain discards both entries.
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", o_we, 32'd0);
    mq.delete();
    mfl = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 4'd5);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 9) < 7, $urandom, 4'($urandom), 4'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 6, 4'($urandom_range(0, 7)));
    repeat (4) step(0, 0, 0, 0, 0, 0, 1, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
